// File: rtl/pi1_ram_slave.sv
// pi1_ram_slave: pi1 responder over a single-ported word RAM with byte-lane writes,
// atomic swap and a programmable number of wait states.
module pi1_ram_slave #(
  parameter int ARCHBITSZ = 32,
  parameter int SIZE = 16,
  parameter int WAITCNT = 0,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o
);
  localparam int AW = $clog2(SIZE);
  localparam int NL = ARCHBITSZ/8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [1:0] op_q;
  logic [AW-1:0] addr_q;
  logic [ARCHBITSZ-1:0] data_q, wdata;
  logic [NL-1:0] sel_q;
  logic [ARCHBITSZ-1:0] mem [SIZE];
  logic acc, done;
  logic unused_addr;
  assign unused_addr = ^pi1_addr_i[ADDRBITSZ-1:AW];
  assign acc = pi1_rdy_o && pi1_op_i != 2'd0;
  assign done = state == BUSY && cnt == 8'd0;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (acc ? BUSY : IDLE) : (cnt == 8'd0 ? IDLE : BUSY);
  always_comb pi1_rdy_o = state == IDLE;
  // op[1] marks a read (RDOP/RWOP), op[0] marks a write (WROP/RWOP)
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt <= '0;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      sel_q <= '0;
      pi1_data_o <= '0;
    end else begin
      if (acc) begin
        cnt <= 8'(WAITCNT);
        op_q <= pi1_op_i;
        addr_q <= pi1_addr_i[AW-1:0];
        data_q <= pi1_data_i;
        sel_q <= pi1_sel_i;
      end else if (state == BUSY && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (done && op_q[1]) pi1_data_o <= mem[addr_q];
    end
  always_comb begin
    wdata = mem[addr_q];
    for (int i = 0; i < NL; i++)
      if (sel_q[i]) wdata[8*i +: 8] = data_q[8*i +: 8];
  end
  always_ff @(posedge clk_i)
    if (done && op_q[0]) mem[addr_q] <= wdata;
endmodule

// File: tb/tb_pi1_ram_slave.sv
// tb_pi1_ram_slave: scoreboard bench for pi1_ram_slave (ARCHBITSZ=32, SIZE=16, WAITCNT=2).
`timescale 1ns/1ns
module tb_pi1_ram_slave;
  logic clk_i = 0, rst_i = 0;
  logic [1:0] pi1_op_i = 0;
  logic [29:0] pi1_addr_i = 0;
  logic [31:0] pi1_data_i = 0, pi1_data_o;
  logic [3:0] pi1_sel_i = 0;
  logic pi1_rdy_o;
  int checks = 0, errors = 0;
  logic [31:0] mem_m [16];
  logic [31:0] last_rd = 0;
  logic [31:0] exp_q [$];
  longint prev_acc = 0;

  pi1_ram_slave #(.ARCHBITSZ(32), .SIZE(16), .WAITCNT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i),
    .pi1_data_i(pi1_data_i), .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i), .pi1_rdy_o(pi1_rdy_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at a negedge with rdy high; returns at the negedge where rdy is back high
  task automatic issue(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] d,
                       input logic [3:0] s, input bit b2b);
    int n;
    logic [31:0] old, nw;
    old = mem_m[addr[3:0]];
    nw = old;
    for (int i = 0; i < 4; i++) if (s[i]) nw[8*i +: 8] = d[8*i +: 8];
    if (op[1]) begin exp_q.push_back(old); last_rd = old; end
    if (op[0]) mem_m[addr[3:0]] = nw;
    pi1_op_i = op; pi1_addr_i = addr; pi1_data_i = d; pi1_sel_i = s;
    @(posedge clk_i);
    if (b2b) chk("gap", 64'($time - prev_acc), 64'd40);
    prev_acc = $time;
    #1 pi1_op_i = 0; pi1_data_i = $urandom; pi1_addr_i = 30'($urandom); pi1_sel_i = 4'($urandom);
    n = 0;
    @(negedge clk_i);
    while (!pi1_rdy_o && n < 20) begin n++; @(negedge clk_i); end
    chk("busy_cycles", 64'(n), 64'd3);
    if (op[1]) chk("rd_data", 64'(pi1_data_o), 64'(exp_q.pop_front()));
    else chk("wr_hold", 64'(pi1_data_o), 64'(last_rd));
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    chk("rst_rdy", 64'(pi1_rdy_o), 64'd1);
    chk("rst_data", 64'(pi1_data_o), 64'd0);
    for (int k = 0; k < 16; k++) issue(2'd1, 30'(k), $urandom, 4'hF, 0);
    chk("pre_rd_data", 64'(pi1_data_o), 64'd0);
    issue(2'd2, 30'd3, 0, 4'h0, 0);
    issue(2'd1, 30'd5, 32'hAABBCCDD, 4'hF, 0);
    issue(2'd2, 30'd5, 0, 4'hF, 0);
    chk("full_wr", 64'(pi1_data_o), 64'hAABBCCDD);
    issue(2'd1, 30'd5, 32'h11223344, 4'hF, 0);
    issue(2'd1, 30'd5, 32'hAABBCCDD, 4'b0101, 0);
    issue(2'd2, 30'd5, 0, 4'h0, 0);
    chk("lane_merge", 64'(pi1_data_o), 64'h11BB33DD);
    issue(2'd1, 30'd7, 32'h42, 4'hF, 0);
    issue(2'd3, 30'd7, 32'hDEADBEEF, 4'hF, 0);
    chk("swap_old", 64'(pi1_data_o), 64'h42);
    issue(2'd2, 30'd7, 0, 4'h0, 0);
    chk("swap_new", 64'(pi1_data_o), 64'hDEADBEEF);
    issue(2'd1, 30'h13, 32'h5, 4'hF, 0);
    issue(2'd2, 30'd3, 0, 4'h0, 0);
    chk("alias", 64'(pi1_data_o), 64'h5);
    issue(2'd2, 30'd5, 0, 4'h0, 1);
    issue(2'd2, 30'd7, 0, 4'h0, 1);
    issue(2'd1, 30'd11, 32'hFFFFFFFF, 4'h0, 1);
    issue(2'd3, 30'd11, 32'h12345678, 4'h0, 1);
    issue(2'd2, 30'd11, 0, 4'h0, 1);
    issue(2'd3, 30'h3FFFFFFC, 32'hCAFEF00D, 4'b1010, 0);
    issue(2'd2, 30'd12, 0, 4'h0, 0);
    // abort a write during its second busy cycle
    pi1_op_i = 2'd1; pi1_addr_i = 30'd9; pi1_data_i = 32'h0BADF00D; pi1_sel_i = 4'hF;
    @(posedge clk_i);
    #1 pi1_op_i = 0;
    @(posedge clk_i);
    #2 rst_i = 0;
    #1;
    chk("mid_rst_rdy", 64'(pi1_rdy_o), 64'd1);
    chk("mid_rst_data", 64'(pi1_data_o), 64'd0);
    last_rd = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    issue(2'd2, 30'd9, 0, 4'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pi1_ram_slave.md
Name: pi1_ram_slave

Overview:
- Responder end of the pi1 peripheral interconnect.
- Presents a single-ported word RAM as a pi1 slave. It attaches to the slave side of the pi1 queue, in the position where multipu's pi1_*_o/pi1_*_i ports terminate.
- Supports read, byte-lane write and atomic read-write (swap), with a programmable number of wait states.
- Used as on-chip boot/scratch memory in multi-PU systems.

Parameters:
- ARCHBITSZ, 32: data width in bits; must be 16, 32 or 64.
- SIZE, 16: RAM depth in ARCHBITSZ-wide words; must be a power of 2 and at least 2.
- WAITCNT, 0: extra busy cycles inserted before each access completes; range 0-255.
- Derived ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous active-low reset.
- pi1_op_i  in  2  0=NOOP, 1=WROP, 2=RDOP, 3=RWOP.
- pi1_addr_i  in  ADDRBITSZ  word address.
- pi1_data_i  in  ARCHBITSZ  write data.
- pi1_data_o  out  ARCHBITSZ  read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte-lane enables.
- pi1_rdy_o  out  1  slave ready / request accepted.

Behaviour:
- Reset (rst_i=0, asynchronous assert):
  - pi1_rdy_o=1, pi1_data_o=0, FSM=IDLE, wait counter=0.
  - RAM contents are not reset and are preserved across reset.
  - Deassertion is synchronous to clk_i (external synchroniser); no request is accepted in the cycle rst_i rises.
- States: IDLE, BUSY.
- IDLE:
  - pi1_rdy_o=1.
  - A request is accepted on a rising edge where pi1_op_i!=0 and pi1_rdy_o=1.
  - On accept, latch op, addr[clog2(SIZE)-1:0], data and sel; load counter=WAITCNT; go to BUSY.
  - pi1_op_i=0 leaves the FSM in IDLE with no side effects.
- BUSY:
  - pi1_rdy_o=0.
  - Counter>0: decrement and stay in BUSY.
  - Counter==0: perform the access and return to IDLE.
- Accesses:
  - RDOP: pi1_data_o <= mem[a]. The full word is returned regardless of sel.
  - WROP: for each lane i with sel[i]=1, mem[a][8i+7:8i] <= data lane i; other lanes keep their value. pi1_data_o is unchanged.
  - RWOP: pi1_data_o <= old mem[a], and the same edge writes the merged word as for WROP. The swap is atomic: no other request can interleave because rdy is low.
- Latency:
  - pi1_rdy_o is low for exactly WAITCNT+1 cycles after the accept edge.
  - pi1_data_o is valid in the first cycle pi1_rdy_o returns to 1.
  - pi1_data_o holds its value until the next RDOP/RWOP completes.
- Back-to-back: in the cycle rdy returns to 1, a new pending op is accepted on that edge. Sustained throughput is one access per WAITCNT+2 cycles.
- Address wrap: the upper address bits beyond clog2(SIZE) are ignored, so address SIZE+k aliases word k.
- sel=0 with WROP: the full handshake still occurs; no RAM change.
- sel=0 with RWOP: returns the old word; no RAM change.
- Inputs change while BUSY: ignored, since latched values are used.
- Reset mid-BUSY: the access is abandoned, no RAM write occurs, and pi1_data_o is cleared to 0.
- Storage is inferred as synchronous RAM. Only one RAM write port and one read are used per completion.

Test Plan (ARCHBITSZ=32, SIZE=16, WAITCNT=2):
- Reset release, then RDOP addr 3 -> rdy low 3 cycles, high on 4th; data_o=previous mem[3]; rdy=1 and data_o=0 before the op.
- WROP addr 5 data 0xAABBCCDD sel=4'hF, then RDOP addr 5 -> data_o=0xAABBCCDD; data_o unchanged during the write.
- Preload mem[5]=0x11223344, WROP addr 5 data 0xAABBCCDD sel=4'b0101, then RDOP 5 -> 0x11BB33DD.
- RWOP addr 7 data 0xDEADBEEF sel=F with mem[7]=0x00000042 -> data_o=0x00000042; subsequent RDOP 7 -> 0xDEADBEEF.
- WROP addr 0x13 data 0x5 sel=F, then RDOP addr 3 -> 0x00000005 (alias wrap). Also cover back-to-back RDOPs accepted on the rdy-rise edge: 4 cycles apart.
- WROP addr 9 accepted; assert rst_i=0 during the second BUSY cycle -> rdy=1 and data_o=0 immediately; after release, RDOP 9 returns the pre-write value.
